// File: rtl/hsv_capture_ctrl.sv
// hsv_capture_ctrl: frame-capture sequencer between the HSV stage and the
// frame-buffer writer. Accepts a capture request, discards a programmable
// number of whole frames, then forwards exactly one frame with x/y tags and a
// saturation/value threshold mask. Reports a good frame, or a short frame, a
// long frame or a vsync timeout.
`timescale 1ns/1ps

module hsv_capture_ctrl #(
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_ACT   = 480,
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_req,
  output logic        cap_ack,
  input  logic [3:0]  skip_n,
  input  logic [7:0]  sat_th_in,
  input  logic [7:0]  val_th_in,
  input  logic        hsv_hs,
  input  logic        hsv_vs,
  input  logic        hsv_de,
  input  logic [23:0] hsv,
  output logic        out_vs,
  output logic        out_de,
  output logic [23:0] out_data,
  output logic        out_mask,
  output logic [9:0]  out_x,
  output logic [8:0]  out_y,
  output logic        busy,
  output logic        cap_done,
  output logic        cap_err
);

  localparam logic [18:0] PIX_TOTAL = 19'(H_ACT * V_ACT);
  localparam logic [9:0]  X_LAST    = 10'(H_ACT - 1);
  localparam logic [23:0] TMO_LAST  = TIMEOUT - 24'd1;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCapture
  } state_t;

  state_t      state;
  logic        hsv_vs_d;
  logic        vs_rise;
  logic        tmo_hit;
  logic        pix_mask;
  logic        pix_room;
  logic [3:0]  skip_cnt;
  logic [23:0] tmo_cnt;
  logic [18:0] pix_cnt;
  logic [9:0]  x_cnt;
  logic [8:0]  y_cnt;
  logic        ovf;
  logic [7:0]  sat_th;
  logic [7:0]  val_th;

  // hsync carries no information the sequencer needs; line structure comes
  // from hsv_de and the configured line length.
  logic unused_hs;
  assign unused_hs = hsv_hs;

  // Decode vsync edge, timeout, pixel mask and frame-capacity conditions.
  always_comb begin
    vs_rise  = hsv_vs & ~hsv_vs_d;
    tmo_hit  = (tmo_cnt == TMO_LAST);
    pix_mask = (hsv[15:8] >= sat_th) && (hsv[7:0] >= val_th);
    pix_room = (pix_cnt < PIX_TOTAL);
  end

  // Registered copy of vsync for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsv_vs_d <= 1'b0;
    end else begin
      hsv_vs_d <= hsv_vs;
    end
  end

  // Capture sequencer with registered status pulses and pixel forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      cap_ack  <= 1'b0;
      out_vs   <= 1'b0;
      out_de   <= 1'b0;
      out_data <= 24'd0;
      out_mask <= 1'b0;
      out_x    <= 10'd0;
      out_y    <= 9'd0;
      busy     <= 1'b0;
      cap_done <= 1'b0;
      cap_err  <= 1'b0;
      skip_cnt <= 4'd0;
      tmo_cnt  <= 24'd0;
      pix_cnt  <= 19'd0;
      x_cnt    <= 10'd0;
      y_cnt    <= 9'd0;
      ovf      <= 1'b0;
      sat_th   <= 8'd0;
      val_th   <= 8'd0;
    end else begin
      // Pulses and the forwarded strobe default low every cycle.
      cap_ack  <= 1'b0;
      out_vs   <= 1'b0;
      out_de   <= 1'b0;
      out_mask <= 1'b0;
      cap_done <= 1'b0;
      cap_err  <= 1'b0;

      unique case (state)
        StIdle: begin
          if (cap_req) begin
            cap_ack  <= 1'b1;
            skip_cnt <= skip_n;
            tmo_cnt  <= 24'd0;
            busy     <= 1'b1;
            state    <= StArm;
          end
        end

        StArm: begin
          if (vs_rise) begin
            tmo_cnt <= 24'd0;
            if (skip_cnt != 4'd0) begin
              skip_cnt <= skip_cnt - 4'd1;
            end else begin
              // Thresholds are frozen here so mid-frame writes cannot split
              // one frame across two mask settings.
              sat_th  <= sat_th_in;
              val_th  <= val_th_in;
              pix_cnt <= 19'd0;
              x_cnt   <= 10'd0;
              y_cnt   <= 9'd0;
              ovf     <= 1'b0;
              out_vs  <= 1'b1;
              state   <= StCapture;
            end
          end else if (tmo_hit) begin
            cap_err <= 1'b1;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end

        StCapture: begin
          if (vs_rise) begin
            // Frame end always returns to idle; a held request is only seen
            // once the sequencer is back in idle.
            tmo_cnt <= 24'd0;
            busy    <= 1'b0;
            state   <= StIdle;
            if ((pix_cnt == PIX_TOTAL) && !ovf) begin
              cap_done <= 1'b1;
            end else begin
              cap_err <= 1'b1;
            end
          end else if (tmo_hit) begin
            cap_err <= 1'b1;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (hsv_de) begin
              if (pix_room) begin
                out_de   <= 1'b1;
                out_data <= hsv;
                out_mask <= pix_mask;
                out_x    <= x_cnt;
                out_y    <= y_cnt;
                pix_cnt  <= pix_cnt + 19'd1;
                if (x_cnt == X_LAST) begin
                  x_cnt <= 10'd0;
                  y_cnt <= y_cnt + 9'd1;
                end else begin
                  x_cnt <= x_cnt + 10'd1;
                end
              end else begin
                // Excess pixels are dropped; the frame is reported as bad.
                ovf <= 1'b1;
              end
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_capture_ctrl.sv
// Directed bench for hsv_capture_ctrl using a reduced 8x4 frame and a
// 100-cycle timeout.
`timescale 1ns/1ps

module tb_hsv_capture_ctrl;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap_req = 1'b0;
  logic        cap_ack;
  logic [3:0]  skip_n = 4'd0;
  logic [7:0]  sat_th_in = 8'd40;
  logic [7:0]  val_th_in = 8'd60;
  logic        hsv_hs = 1'b0;
  logic        hsv_vs = 1'b0;
  logic        hsv_de = 1'b0;
  logic [23:0] hsv = 24'd0;
  logic        out_vs;
  logic        out_de;
  logic [23:0] out_data;
  logic        out_mask;
  logic [9:0]  out_x;
  logic [8:0]  out_y;
  logic        busy;
  logic        cap_done;
  logic        cap_err;

  hsv_capture_ctrl #(
    .H_ACT   (H),
    .V_ACT   (V),
    .TIMEOUT (24'd100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_req   (cap_req),
    .cap_ack   (cap_ack),
    .skip_n    (skip_n),
    .sat_th_in (sat_th_in),
    .val_th_in (val_th_in),
    .hsv_hs    (hsv_hs),
    .hsv_vs    (hsv_vs),
    .hsv_de    (hsv_de),
    .hsv       (hsv),
    .out_vs    (out_vs),
    .out_de    (out_de),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .cap_done  (cap_done),
    .cap_err   (cap_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Output monitor, sampled on the falling edge.
  int          cyc = 0;
  int          n_de = 0, n_vs = 0, n_done = 0, n_err = 0, n_ack = 0, n_overlap = 0;
  int          pix_idx = 0, ack_cyc = 0, err_cyc = 0;
  logic        mask0 = 1'b0, mask1 = 1'b0, mask10 = 1'b0;
  logic [23:0] data0 = 24'd0;
  logic [9:0]  last_x = 10'd0;
  logic [8:0]  last_y = 9'd0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_vs) begin
      n_vs    = n_vs + 1;
      pix_idx = 0;
    end
    if (out_de) begin
      n_de = n_de + 1;
      if (pix_idx == 0) begin
        mask0 = out_mask;
        data0 = out_data;
      end
      if (pix_idx == 1) mask1 = out_mask;
      if (pix_idx == 10) mask10 = out_mask;
      last_x  = out_x;
      last_y  = out_y;
      pix_idx = pix_idx + 1;
    end
    if (cap_done) n_done = n_done + 1;
    if (cap_err) begin
      n_err   = n_err + 1;
      err_cyc = cyc;
    end
    if (cap_ack) begin
      n_ack   = n_ack + 1;
      ack_cyc = cyc;
    end
    if ((cap_done && cap_err) || ((cap_done || cap_err) && cap_ack)) n_overlap = n_overlap + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_errors = n_errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel pattern: idx0 = {0,40,60}, idx1 and idx10 = {0,39,200}, else sat/val 100.
  function automatic logic [23:0] pix(input int idx);
    if (idx == 0) return 24'h00283C;
    if (idx == 1 || idx == 10) return 24'h0027C8;
    return {8'(idx), 8'd100, 8'd100};
  endfunction

  task automatic request(input logic [3:0] s);
    cap_req = 1'b1;
    skip_n  = s;
    chk("ack_before_edge", cap_ack, 0);
    tick();
    cap_req = 1'b0;
    chk("ack_after_edge", cap_ack, 1);
  endtask

  // One frame: vsync pulse, then `lines` lines of H pixels. Optional mid-frame
  // threshold write at pixel 5 and optional reset at pixel `abort_at`.
  task automatic frame(input int lines, input int abort_at, input bit chg, output bit vs_seen);
    int idx = 0;
    hsv_vs = 1'b1;
    tick();
    vs_seen = out_vs;
    tick();
    hsv_vs = 1'b0;
    tick();
    tick();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < int'(H); p++) begin
        if (idx == abort_at) begin
          rst    = 1'b0;
          hsv_de = 1'b0;
          #1;
          chk("reset_outputs_zero",
              {busy, cap_ack, out_vs, out_de, out_mask, cap_done, cap_err,
               out_data, out_x, out_y}, 64'd0);
          return;
        end
        if (chg && idx == 5) sat_th_in = 8'd0;
        hsv_de = 1'b1;
        hsv    = pix(idx);
        tick();
        idx++;
      end
      hsv_de = 1'b0;
      hsv_hs = 1'b1;
      tick();
      hsv_hs = 1'b0;
      tick();
    end
  endtask

  task automatic vs_end();
    hsv_vs = 1'b1;
    tick();
    tick();
    hsv_vs = 1'b0;
    tick();
  endtask

  initial begin
    int  de0, done0, err0, ack0;
    bit  vs_seen;
    bit  got;

    // Reset state
    #12;
    chk("reset_state",
        {busy, cap_ack, out_vs, out_de, out_mask, cap_done, cap_err, out_data, out_x, out_y},
        64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Nominal capture with mid-frame threshold write
    de0 = n_de; done0 = n_done; err0 = n_err;
    request(4'd0);
    chk("busy_armed", busy, 1);
    frame(V, -1, 1'b1, vs_seen);
    chk("nom_out_vs_after_rise", vs_seen, 1);
    vs_end();
    chk("nom_de_count", n_de - de0, 32);
    chk("nom_last_x", last_x, 7);
    chk("nom_last_y", last_y, 3);
    chk("nom_done", n_done - done0, 1);
    chk("nom_no_err", n_err - err0, 0);
    chk("nom_busy_low", busy, 0);
    chk("mask_pix0", mask0, 1);
    chk("mask_pix1", mask1, 0);
    chk("data_pix0", data0, 24'h00283C);
    chk("mask_shadow_held", mask10, 0);

    // Next capture picks up sat_th_in = 0
    request(4'd0);
    frame(V, -1, 1'b0, vs_seen);
    vs_end();
    chk("mask_next_capture", mask1, 1);
    sat_th_in = 8'd40;

    // Frame skip of two
    de0 = n_de; done0 = n_done;
    request(4'd2);
    frame(V, -1, 1'b0, vs_seen);
    chk("skip1_no_vs", vs_seen, 0);
    frame(V, -1, 1'b0, vs_seen);
    chk("skip2_no_vs", vs_seen, 0);
    chk("skip_no_de", n_de - de0, 0);
    frame(V, -1, 1'b0, vs_seen);
    chk("skip3_vs", vs_seen, 1);
    vs_end();
    chk("skip_de_count", n_de - de0, 32);
    chk("skip_one_done", n_done - done0, 1);

    // Short frame
    de0 = n_de; done0 = n_done; err0 = n_err;
    request(4'd0);
    frame(V - 1, -1, 1'b0, vs_seen);
    vs_end();
    chk("short_de", n_de - de0, 24);
    chk("short_err", n_err - err0, 1);
    chk("short_no_done", n_done - done0, 0);

    // Long frame
    de0 = n_de; done0 = n_done; err0 = n_err;
    request(4'd0);
    frame(V + 1, -1, 1'b0, vs_seen);
    vs_end();
    chk("long_de_capped", n_de - de0, 32);
    chk("long_err", n_err - err0, 1);
    chk("long_no_done", n_done - done0, 0);

    // Timeout with vsync held low
    err0 = n_err;
    got  = 1'b0;
    request(4'd0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_err != err0) begin
        got = 1'b1;
        break;
      end
    end
    chk("tmo_seen", got, 1);
    chk("tmo_latency", err_cyc - ack_cyc, 100);
    chk("tmo_busy_low", busy, 0);

    // Reset mid-capture
    done0 = n_done; err0 = n_err;
    request(4'd0);
    frame(V, 12, 1'b0, vs_seen);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_no_done", n_done - done0, 0);
    chk("rst_no_err", n_err - err0, 0);
    chk("rst_idle", busy, 0);

    // Request while busy is ignored
    ack0 = n_ack; done0 = n_done;
    request(4'd0);
    tick();
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    chk("busy_req_no_ack", cap_ack, 0);
    tick();
    chk("busy_req_ack_count", n_ack - ack0, 1);
    chk("busy_still_armed", busy, 1);
    frame(V, -1, 1'b0, vs_seen);
    vs_end();
    chk("busy_case_done", n_done - done0, 1);

    chk("pulse_exclusive", n_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hsv_capture_ctrl.md
Name: hsv_capture_ctrl

Overview:
- Frame-capture sequencer between the HSV conversion stage and the frame-buffer writer in the send-frames-to-IoT path.
- Accepts a capture request, waits a programmable number of whole frames, then gates exactly one complete HSV frame downstream.
- Tags each forwarded pixel with x/y coordinates and a saturation/value threshold mask, and reports done or error.
- Threshold configuration is shadowed and latched at frame start.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- TIMEOUT, 24'd5_000_000, clk cycles allowed without a vs rising edge while armed or capturing.

Ports:
- clk  in  1  pixel clock, same domain as the HSV stage.
- rst  in  1  asynchronous, active-low reset.
- cap_req  in  1  capture request, level; sampled only in IDLE.
- cap_ack  out  1  one-cycle pulse when the request is accepted.
- skip_n  in  4  number of full frames to discard after accept; sampled at accept.
- sat_th_in  in  8  saturation threshold, shadow input.
- val_th_in  in  8  value threshold, shadow input.
- hsv_hs  in  1  HSV-stage hsync.
- hsv_vs  in  1  HSV-stage vsync, active-high.
- hsv_de  in  1  HSV-stage data enable.
- hsv  in  24  {hue, saturation, value}.
- out_vs  out  1  frame-start pulse toward the writer.
- out_de  out  1  forwarded data enable.
- out_data  out  24  forwarded hsv.
- out_mask  out  1  high when sat >= sat_th and val >= val_th.
- out_x  out  10  column of the forwarded pixel.
- out_y  out  9  row of the forwarded pixel.
- busy  out  1  high in ARM or CAPTURE.
- cap_done  out  1  one-cycle pulse when a good frame completes.
- cap_err  out  1  one-cycle pulse on a short/long frame or timeout.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0; counters 0; sat_th/val_th shadows 0.
  - Reset in any state aborts the capture; no done or err pulse is issued.
- vs edge: vs_rise = hsv_vs & ~hsv_vs_d, where hsv_vs_d is a registered copy of hsv_vs.
- IDLE:
  - If cap_req=1: pulse cap_ack, load skip_cnt=skip_n, clear tmo_cnt, go to ARM.
  - cap_req is ignored in every other state; no ack is given.
- ARM:
  - tmo_cnt increments each cycle and clears on vs_rise.
  - vs_rise with skip_cnt!=0: skip_cnt decrements; stay in ARM.
  - vs_rise with skip_cnt==0: latch sat_th_in/val_th_in into the shadows, clear pix_cnt/x/y, pulse out_vs (registered, next cycle), go to CAPTURE.
  - tmo_cnt reaches TIMEOUT-1: pulse cap_err, go to IDLE.
  - skip_n=0: the first vs_rise after accept starts the capture.
- CAPTURE:
  - Each hsv_de=1 cycle is forwarded with 1-cycle registered latency: out_de=1, out_data=hsv, out_mask computed against the shadows, out_x/out_y = current x/y.
  - x increments per pixel and wraps to 0 at H_ACT-1; y then increments.
  - pix_cnt is 19 bits and counts all forwarded pixels.
  - Pixels beyond H_ACT*V_ACT are not forwarded (out_de=0); an overflow flag is set.
  - Next vs_rise ends the frame and returns the state to IDLE:
    - pix_cnt==H_ACT*V_ACT and no overflow: pulse cap_done.
    - Otherwise: pulse cap_err.
  - The same timeout rule as ARM applies and pulses cap_err.
  - A vs_rise that ends a frame does not re-arm, even if cap_req is held high. A new request is accepted from the cycle after the return to IDLE.
- Outside CAPTURE: out_de=0, out_mask=0; out_data holds its last value.
- Threshold writes during CAPTURE do not affect the current frame.
- busy = (state==ARM) | (state==CAPTURE), registered.
- cap_done and cap_err are mutually exclusive and never high in the same cycle as cap_ack.

Test Plan:
- Nominal capture:
  - Stimulus: reset; cap_req=1 for one cycle with skip_n=0; 640x480 frames; sat_th=8'd40, val_th=8'd60.
  - Required: cap_ack 1 cycle after the req edge; out_vs 1 cycle after the first vs_rise; 307200 out_de pulses; last pixel at x=639, y=479; cap_done at the next vs_rise; busy low afterwards.
- Frame skip:
  - Stimulus: skip_n=4'd2.
  - Required: frames 1–2 after accept produce no out_de; frame 3 is forwarded; exactly one cap_done.
- Threshold mask and shadowing:
  - Stimulus: pixel {0,40,60} then {0,39,200}; change sat_th_in to 0 mid-frame.
  - Required: out_mask = 1 then 0; the mid-frame change has no effect until the next capture.
- Short and long frames:
  - Stimulus: a frame with 479 lines, then a capture with 481 lines.
  - Required: cap_err in both cases, no cap_done; at most 307200 out_de pulses in the long case.
- Timeout:
  - Stimulus: vs held low after accept, with TIMEOUT overridden to 100.
  - Required: cap_err exactly 100 cycles after the last tmo clear; state returns to IDLE.
- Reset mid-capture and request handling:
  - Stimulus: assert rst at pixel 1000.
  - Required: all outputs 0 immediately; no done or err pulse.
  - Stimulus: after reset release, a req pulse while busy.
  - Required: the req pulse while busy receives no ack.
